// File: rtl/alioth_soc_rst_seq.sv
// SoC reset/boot sequencer: sync, fabric hold, staggered hart release, soft resets.
// Optional watchdog enabled by defining ALIOTH_SOC_WDT_EN.
module alioth_soc_rst_seq #(
    parameter int unsigned NUM_HARTS       = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned STAGGER_CYCLES  = 4,
    parameter int unsigned WDT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sw_rst_req_i,
    input  logic [NUM_HARTS-1:0] hart_rst_req_i,
    output logic                 soc_rst_n_o,
    output logic [NUM_HARTS-1:0] hart_rst_n_o,
    output logic                 boot_done_o,
    output logic                 busy_o,
    input  logic                 wdt_kick_i,
    output logic                 wdt_timeout_o
);

    localparam int unsigned CMAX = (RST_HOLD_CYCLES > STAGGER_CYCLES) ?
                                   RST_HOLD_CYCLES : STAGGER_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned IW   = $clog2(NUM_HARTS + 1);
    localparam int unsigned SW   = SYNC_STAGES - 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(RST_HOLD_CYCLES);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CMAX);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_HARTS - 1);
    localparam logic [SW-1:0] SYNC_ONE  = SW'(1);

    typedef enum logic [1:0] {
        S_SYNC,
        S_HOLD,
        S_STAG,
        S_RUN
    } state_e;

    state_e                 state_q, state_d;
    logic [SW-1:0]          sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          hcnt_q [NUM_HARTS];
    logic [CW-1:0]          hcnt_d [NUM_HARTS];
    logic                   soc_q, soc_d;
    logic [NUM_HARTS-1:0]   hart_q, hart_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   wdt_fire;
    logic                   full_rst;

    // The FSM state register acts as the final synchroniser stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_ONE;
        end
    end

`ifdef ALIOTH_SOC_WDT_EN
    logic [WDT_WIDTH-1:0] wdt_q, wdt_d;
    logic                 wto_q;

    assign wdt_fire = (state_q == S_RUN) && !wdt_kick_i &&
                      (wdt_q <= WDT_WIDTH'(1));

    // Held at all-ones outside RUN so entry to RUN starts a full period.
    always_comb begin
        wdt_d = '1;
        if (state_q == S_RUN && !wdt_kick_i && wdt_q != '0) begin
            wdt_d = wdt_q - WDT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_q <= '1;
            wto_q <= 1'b0;
        end else begin
            wdt_q <= wdt_d;
            wto_q <= wto_q | wdt_fire;
        end
    end

    assign wdt_timeout_o = wto_q;
`else
    logic [WDT_WIDTH-1:0] unused_wdt;

    assign unused_wdt    = {WDT_WIDTH{wdt_kick_i}};
    assign wdt_fire      = 1'b0;
    assign wdt_timeout_o = 1'b0;
`endif

    assign full_rst = (sw_rst_req_i | wdt_fire) && (state_q != S_SYNC);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        soc_d   = soc_q;
        hart_d  = hart_q;
        done_d  = done_q;
        busy_d  = busy_q;
        for (int i = 0; i < NUM_HARTS; i++) begin
            hcnt_d[i] = hcnt_q[i];
        end

        unique case (state_q)
            S_SYNC: begin
                if (sync_q[SW-1]) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    soc_d   = 1'b1;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_STAG;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STAG: begin
                if (cnt_q == STAG_LAST) begin
                    for (int i = 0; i < NUM_HARTS; i++) begin
                        if (idx_q == IW'(i)) begin
                            hart_d[i] = 1'b1;
                        end
                    end
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                for (int i = 0; i < NUM_HARTS; i++) begin
                    if (hart_rst_req_i[i]) begin
                        hcnt_d[i] = HOLD_LOAD;
                    end else if (hcnt_q[i] != '0) begin
                        hcnt_d[i] = hcnt_q[i] - CW'(1);
                    end
                    hart_d[i] = (hcnt_d[i] == '0);
                    if (hcnt_d[i] != '0) begin
                        done_d = 1'b0;
                        busy_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase

        // Full reset overrides everything, including per-hart activity.
        if (full_rst) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            soc_d   = 1'b0;
            hart_d  = '0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
            for (int i = 0; i < NUM_HARTS; i++) begin
                hcnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_SYNC;
            cnt_q   <= '0;
            idx_q   <= '0;
            soc_q   <= 1'b0;
            hart_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            for (int i = 0; i < NUM_HARTS; i++) begin
                hcnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            soc_q   <= soc_d;
            hart_q  <= hart_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            for (int i = 0; i < NUM_HARTS; i++) begin
                hcnt_q[i] <= hcnt_d[i];
            end
        end
    end

    assign soc_rst_n_o  = soc_q;
    assign hart_rst_n_o = hart_q;
    assign boot_done_o  = done_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_alioth_soc_rst_seq.sv
// Bench for alioth_soc_rst_seq: vector table plus async-reset and watchdog cases.
// Watchdog cases compile only when ALIOTH_SOC_WDT_EN is defined.
module tb_alioth_soc_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic [1:0] hart_rst_req = 2'b00;
    logic       wdt_kick = 1'b0;
    logic       soc_rst_n;
    logic [1:0] hart_rst_n;
    logic       boot_done;
    logic       busy;
    logic       wdt_timeout;

    int cyc;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int         c;
        logic       sw;
        logic [1:0] hreq;
        logic       soc;
        logic [1:0] hart;
        logic       done;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    alioth_soc_rst_seq #(
        .NUM_HARTS      (2),
        .SYNC_STAGES    (2),
        .RST_HOLD_CYCLES(16),
        .STAGGER_CYCLES (4),
        .WDT_WIDTH      (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw_rst_req_i  (sw_rst_req),
        .hart_rst_req_i(hart_rst_req),
        .soc_rst_n_o   (soc_rst_n),
        .hart_rst_n_o  (hart_rst_n),
        .boot_done_o   (boot_done),
        .busy_o        (busy),
        .wdt_kick_i    (wdt_kick),
        .wdt_timeout_o (wdt_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d",
                      name, cyc, got, exp);
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != n) chk("wait_cyc", cyc, n);
    endtask

    task automatic add(input int c, input logic sw, input logic [1:0] hreq,
                       input logic soc, input logic [1:0] hart,
                       input logic done, input logic bsy);
        vec_t v;
        v.c = c; v.sw = sw; v.hreq = hreq;
        v.soc = soc; v.hart = hart; v.done = done; v.busy = bsy;
        tbl.push_back(v);
    endtask

    task automatic chk_all(input string tag, input logic soc, input logic [1:0] hart,
                           input logic done, input logic bsy);
        chk({tag, ".soc"},  int'(soc_rst_n),  int'(soc));
        chk({tag, ".hart"}, int'(hart_rst_n), int'(hart));
        chk({tag, ".done"}, int'(boot_done),  int'(done));
        chk({tag, ".busy"}, int'(busy),       int'(bsy));
    endtask

    task automatic release_rst;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic assert_rst;
        #2;
        rst_n = 1'b0;
        #1;
    endtask

    initial begin
        // power-on, per-hart, sw reset, collisions, restarts
        add(  0, 0, 2'b00, 0, 2'b00, 0, 1);
        add( 17, 0, 2'b00, 0, 2'b00, 0, 1);
        add( 18, 0, 2'b00, 1, 2'b00, 0, 1);
        add( 21, 0, 2'b00, 1, 2'b00, 0, 1);
        add( 22, 0, 2'b00, 1, 2'b01, 0, 1);
        add( 25, 0, 2'b00, 1, 2'b01, 0, 1);
        add( 26, 0, 2'b00, 1, 2'b11, 1, 0);
        add( 40, 0, 2'b10, 1, 2'b11, 1, 0);
        add( 41, 0, 2'b00, 1, 2'b01, 0, 1);
        add( 56, 0, 2'b00, 1, 2'b01, 0, 1);
        add( 57, 0, 2'b00, 1, 2'b11, 1, 0);
        add( 70, 1, 2'b00, 1, 2'b11, 1, 0);
        add( 71, 0, 2'b00, 0, 2'b00, 0, 1);
        add( 86, 0, 2'b00, 0, 2'b00, 0, 1);
        add( 87, 0, 2'b00, 1, 2'b00, 0, 1);
        add( 90, 0, 2'b00, 1, 2'b00, 0, 1);
        add( 91, 0, 2'b00, 1, 2'b01, 0, 1);
        add( 94, 0, 2'b00, 1, 2'b01, 0, 1);
        add( 95, 0, 2'b00, 1, 2'b11, 1, 0);
        add(110, 1, 2'b01, 1, 2'b11, 1, 0);
        add(111, 0, 2'b00, 0, 2'b00, 0, 1);
        add(127, 0, 2'b00, 1, 2'b00, 0, 1);
        add(131, 0, 2'b00, 1, 2'b01, 0, 1);
        add(135, 0, 2'b00, 1, 2'b11, 1, 0);
        add(150, 0, 2'b11, 1, 2'b11, 1, 0);
        add(151, 0, 2'b00, 1, 2'b00, 0, 1);
        add(166, 0, 2'b00, 1, 2'b00, 0, 1);
        add(167, 0, 2'b00, 1, 2'b11, 1, 0);
        add(180, 0, 2'b01, 1, 2'b11, 1, 0);
        add(181, 0, 2'b01, 1, 2'b10, 0, 1);
        add(182, 0, 2'b00, 1, 2'b10, 0, 1);
        add(197, 0, 2'b00, 1, 2'b10, 0, 1);
        add(198, 0, 2'b00, 1, 2'b11, 1, 0);
        add(200, 1, 2'b00, 1, 2'b11, 1, 0);
        add(201, 0, 2'b10, 0, 2'b00, 0, 1);
        add(202, 0, 2'b00, 0, 2'b00, 0, 1);
        add(210, 1, 2'b00, 0, 2'b00, 0, 1);
        add(211, 0, 2'b00, 0, 2'b00, 0, 1);
        add(217, 0, 2'b00, 0, 2'b00, 0, 1);
        add(226, 0, 2'b00, 0, 2'b00, 0, 1);
        add(227, 0, 2'b00, 1, 2'b00, 0, 1);
        add(229, 1, 2'b00, 1, 2'b00, 0, 1);
        add(230, 0, 2'b00, 0, 2'b00, 0, 1);
        add(245, 0, 2'b00, 0, 2'b00, 0, 1);
        add(246, 0, 2'b00, 1, 2'b00, 0, 1);
        add(250, 0, 2'b00, 1, 2'b01, 0, 1);
        add(254, 0, 2'b00, 1, 2'b11, 1, 0);

`ifdef ALIOTH_SOC_WDT_EN
        wdt_kick = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_all("in_reset", 1'b0, 2'b00, 1'b0, 1'b1);
        chk("in_reset.wdt", int'(wdt_timeout), 0);

        release_rst();
        foreach (tbl[k]) begin
            wait_cyc(tbl[k].c);
            chk_all($sformatf("vec%0d", k), tbl[k].soc, tbl[k].hart,
                    tbl[k].done, tbl[k].busy);
            chk($sformatf("vec%0d.wdt", k), int'(wdt_timeout), 0);
            sw_rst_req   = tbl[k].sw;
            hart_rst_req = tbl[k].hreq;
        end

        // asynchronous reset in the middle of the stagger phase
        assert_rst();
        release_rst();
        wait_cyc(20);
        chk_all("pre_async", 1'b1, 2'b00, 1'b0, 1'b1);
        assert_rst();
        chk_all("async", 1'b0, 2'b00, 1'b0, 1'b1);
        release_rst();
        wait_cyc(17);
        chk_all("re17", 1'b0, 2'b00, 1'b0, 1'b1);
        wait_cyc(18);
        chk_all("re18", 1'b1, 2'b00, 1'b0, 1'b1);
        wait_cyc(22);
        chk_all("re22", 1'b1, 2'b01, 1'b0, 1'b1);
        wait_cyc(26);
        chk_all("re26", 1'b1, 2'b11, 1'b1, 1'b0);

`ifdef ALIOTH_SOC_WDT_EN
        // no kicks: fires 15 cycles after entering RUN
        assert_rst();
        wdt_kick = 1'b0;
        release_rst();
        wait_cyc(40);
        chk("wdt40", int'(wdt_timeout), 0);
        chk_all("wdt40", 1'b1, 2'b11, 1'b1, 1'b0);
        wait_cyc(41);
        chk("wdt41", int'(wdt_timeout), 1);
        chk_all("wdt41", 1'b0, 2'b00, 1'b0, 1'b1);
        wait_cyc(57);
        chk_all("wdt57", 1'b1, 2'b00, 1'b0, 1'b1);
        wait_cyc(65);
        chk_all("wdt65", 1'b1, 2'b11, 1'b1, 1'b0);
        chk("wdt65", int'(wdt_timeout), 1);
        assert_rst();
        chk("wdt_clr", int'(wdt_timeout), 0);
        // periodic kick every 8 cycles keeps it quiet
        release_rst();
        for (int c = 27; c <= 120; c++) begin
            wait_cyc(c);
            wdt_kick = ((c % 8) == 0);
        end
        wdt_kick = 1'b0;
        chk("wdt_kicked", int'(wdt_timeout), 0);
        chk_all("wdt_kicked", 1'b1, 2'b11, 1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
